// File: rtl/alu_pkg.sv
// Shared definitions for the ALU breadboard: divider FSM states, default
// widths, the divide-by-zero fill bit and the iteration-counter width helper.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEF     = 16;
  localparam int unsigned OUT_WIDTH_DEF = 32;

  // Every result bit takes this value when the divisor is zero.
  localparam logic DIVZERO_FILL = 1'b1;

  // Width of a counter that indexes WIDTH iterations (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the result if it did
// not borrow, and shift the matching quotient bit in.
module div_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // Since rem < divisor, a non-borrowing trial always fits back in WIDTH bits.
  always_comb begin
    w_shift = {i_rem, i_q[WIDTH-1]};
    w_trial = w_shift - {1'b0, i_div};
    if (w_trial[WIDTH] == 1'b0) begin
      o_rem = w_trial[WIDTH-1:0];
      o_q   = {i_q[WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_shift[WIDTH-1:0];
      o_q   = {i_q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// zero-extended quotient/remainder, all-ones results on divide-by-zero.
module seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     inputA,
  input  logic [WIDTH-1:0]     inputB,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] resDiv,
  output logic [OUT_WIDTH-1:0] resMod,
  output logic                 divZero
);

  localparam int unsigned     CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [CW-1:0]        r_count;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     w_rem_next;
  logic [WIDTH-1:0]     w_q_next;
  logic                 r_done;
  logic                 r_div_zero;
  logic [OUT_WIDTH-1:0] r_res_div;
  logic [OUT_WIDTH-1:0] r_res_mod;
  logic                 w_accept;
  logic                 w_b_zero;
  logic                 w_last;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem(r_rem),
    .i_q  (r_q),
    .i_div(r_b),
    .o_rem(w_rem_next),
    .o_q  (w_q_next)
  );

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_b_zero = (inputB == '0);
  assign w_last   = (r_count == LAST);

  assign busy    = (r_state == RUN);
  assign done    = r_done;
  assign resDiv  = r_res_div;
  assign resMod  = r_res_mod;
  assign divZero = r_div_zero;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; DONE accepts a new start just like IDLE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, DONE: if (w_accept) w_state_next = w_b_zero ? DONE : RUN;
      RUN:        if (w_last)   w_state_next = DONE;
      default:    w_state_next = IDLE;
    endcase
  end

  // Operand latch, iteration datapath, counter and result registers.
  // The last RUN step commits the divider's next values straight into the
  // results so DONE is reached after exactly WIDTH iterations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_b        <= '0;
      r_q        <= '0;
      r_rem      <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_res_div  <= '0;
      r_res_mod  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            if (w_b_zero) begin
              r_res_div  <= {OUT_WIDTH{DIVZERO_FILL}};
              r_res_mod  <= {OUT_WIDTH{DIVZERO_FILL}};
              r_div_zero <= 1'b1;
              r_done     <= 1'b1;
            end else begin
              r_b     <= inputB;
              r_q     <= inputA;
              r_rem   <= '0;
              r_count <= '0;
            end
          end
        end
        RUN: begin
          r_rem   <= w_rem_next;
          r_q     <= w_q_next;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_res_div  <= OUT_WIDTH'(w_q_next);
            r_res_mod  <= OUT_WIDTH'(w_rem_next);
            r_div_zero <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotients, remainders,
// latencies and flag behaviour, checked with immediate assertions.
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] inputA;
  logic [15:0] inputB;
  logic        busy;
  logic        done;
  logic [31:0] resDiv;
  logic [31:0] resMod;
  logic        divZero;

  int checks = 0;
  int errors = 0;

  seq_divider #(
    .WIDTH    (16),
    .OUT_WIDTH(32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .inputA (inputA),
    .inputB (inputB),
    .busy   (busy),
    .done   (done),
    .resDiv (resDiv),
    .resMod (resMod),
    .divZero(divZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents operands with start for one edge; returns at the negedge after
  // the accepting edge (first cycle after acceptance).
  task automatic pulse_start(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    inputA = a;
    inputB = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Counts negedge samples (starting at 1) until done is seen, bounded.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat         = 1;
    busy_cycles = 0;
    while (done !== 1'b1 && lat < 64) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int elat);
    int lat;
    int bc;
    pulse_start(a, b);
    wait_done(lat, bc);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, resDiv, eq);
    chk({tag, "_r"}, resMod, er);
    chk({tag, "_dz"}, divZero, edz);
  endtask

  initial begin
    int lat;
    int bc;
    int seen_done;

    reset  = 1'b1;
    start  = 1'b0;
    inputA = '0;
    inputB = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", resDiv, 0);
    chk("rst_r", resMod, 0);
    chk("rst_dz", divZero, 0);

    // 1: 9 / 6
    run_op("t1", 16'd9, 16'd6, 32'd1, 32'd3, 1'b0, 17);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_hold_q", resDiv, 32'd1);

    // 2: 32000 / 900, busy for exactly 16 cycles
    pulse_start(16'd32000, 16'd900);
    chk("t2_hold_during_run", resDiv, 32'd1);
    wait_done(lat, bc);
    chk("t2_lat", lat, 17);
    chk("t2_busy_cycles", bc, 16);
    chk("t2_q", resDiv, 32'd35);
    chk("t2_r", resMod, 32'd500);

    // 3: divide by zero, then a normal op clears divZero
    run_op("t3z", 16'd1234, 16'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("t3", 16'd10, 16'd3, 32'd3, 32'd1, 1'b0, 17);

    // 4: extremes and zero dividend
    run_op("t4a", 16'd65535, 16'd1, 32'd65535, 32'd0, 1'b0, 17);
    chk("t4a_upper", {16'd0, resDiv[31:16]}, 0);
    run_op("t4b", 16'd5, 16'd65535, 32'd0, 32'd5, 1'b0, 17);
    chk("t4b_upper", {16'd0, resMod[31:16]}, 0);
    run_op("t4c", 16'd0, 16'd7, 32'd0, 32'd0, 1'b0, 17);

    // 5: start while busy is ignored; start coincident with done is accepted
    pulse_start(16'd100, 16'd7);
    repeat (3) @(negedge clk);
    pulse_start(16'd200, 16'd3);
    chk("t5_busy_mid", busy, 1);
    wait_done(lat, bc);
    chk("t5_lat", lat, 12);
    chk("t5_q", resDiv, 32'd14);
    chk("t5_r", resMod, 32'd2);
    inputA = 16'd1000;
    inputB = 16'd33;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_b2b_busy", busy, 1);
    wait_done(lat, bc);
    chk("t5_b2b_lat", lat, 17);
    chk("t5_b2b_q", resDiv, 32'd30);
    chk("t5_b2b_r", resMod, 32'd10);

    // 6: asynchronous reset mid-RUN after a divide-by-zero left divZero set
    run_op("t6z", 16'd1, 16'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);
    pulse_start(16'd50000, 16'd7);
    inputA = 16'd3;
    inputB = 16'd2;
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_q", resDiv, 0);
    chk("t6_r", resMod, 0);
    chk("t6_dz", divZero, 0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1;
    end
    chk("t6_no_done", seen_done, 0);
    run_op("t6", 16'd50000, 16'd7, 32'd7142, 32'd6, 1'b0, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
